// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave / RAM slice: slave FSM states,
// command codes carried in the top two bits of each frame, frame length.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // {cmd[1:0], payload[7:0]}
  localparam int unsigned FRAME_LEN = 10;

endpackage

// File: rtl/spi_ram.sv
// 256 x 8 single-port RAM driven by completed SPI frames.
// Optional feature macro: SPI_WR_AUTOINC_EN -- when defined, every data-write
// frame post-increments the write address (mod 256) so bursts need only one
// address frame.
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid
);

  logic [ADDR_SIZE-1:0] mem [0:MEM_DEPTH-1];

  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_SIZE-1:0] dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [1:0]           cmd;

  assign cmd      = din[ADDR_SIZE+1 -: 2];
  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

  // Decode a completed frame into address updates or a read-data request
  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        CMD_WR_ADDR: wr_addr_d = din[ADDR_SIZE-1:0];
        CMD_WR_DATA: begin
`ifdef SPI_WR_AUTOINC_EN
          wr_addr_d = wr_addr_q + 1'b1;
`else
          wr_addr_d = wr_addr_q;
`endif
        end
        CMD_RD_ADDR: rd_addr_d = din[ADDR_SIZE-1:0];
        CMD_RD_DATA: begin
          dout_d     = mem[rd_addr_q];
          tx_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address / read-data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Storage write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (rx_valid && (cmd == CMD_WR_DATA)) begin
      mem[wr_addr_q] <= din[ADDR_SIZE-1:0];
    end
  end

endmodule

// File: rtl/spi_top_module.sv
// SPI mode-0 slave front-end (clk doubles as bit clock) fronting a 256 x 8 RAM.
// Receives 10-bit frames {cmd, payload} MSB first on mosi, returns read data
// MSB first on miso. Optional feature macro: SPI_WR_AUTOINC_EN (see spi_ram).
module spi_top_module
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic mosi,
  input  logic ss_n,
  input  logic clk,
  input  logic rst_n,
  output logic miso
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
  localparam int unsigned         TX_CNT_W = $clog2(ADDR_SIZE);
  localparam logic [TX_CNT_W-1:0] TX_LAST  = TX_CNT_W'(ADDR_SIZE - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-1:0]  rx_data_q, rx_data_d;
  logic [FRAME_LEN-1:0]  rx_shift;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rd_addr_valid_q, rd_addr_valid_d;
  logic [ADDR_SIZE-1:0]  tx_shift_q, tx_shift_d;
  logic [TX_CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic                  tx_active_q, tx_active_d;
  logic                  miso_q, miso_d;
  logic [ADDR_SIZE-1:0]  ram_dout;
  logic                  ram_tx_valid;

  assign miso     = miso_q;
  assign rx_shift = {rx_data_q[FRAME_LEN-2:0], mosi};

  spi_ram #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (rx_data_q),
    .rx_valid (rx_valid_q),
    .dout     (ram_dout),
    .tx_valid (ram_tx_valid)
  );

  // Next-state logic: frame reception, command tracking and miso serialiser
  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    rd_addr_valid_d = rd_addr_valid_q;
    tx_shift_d      = tx_shift_q;
    tx_cnt_d        = tx_cnt_q;
    tx_active_d     = tx_active_q;
    miso_d          = 1'b0;

    if (ss_n) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      tx_cnt_d    = '0;
      tx_active_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = CHK_CMD;

        CHK_CMD: begin
          rx_data_d = rx_shift;
          bit_cnt_d = CNT_W'(1);
          if (!mosi) begin
            state_d = WRITE;
          end else if (!rd_addr_valid_q) begin
            state_d = READ_ADD;
          end else begin
            state_d = READ_DATA;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (bit_cnt_q < FULL_CNT) begin
            rx_data_d = rx_shift;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_valid_d = 1'b1;
              // Read-address tracking follows the decoded command rather than
              // the FSM branch, so it stays right even for out-of-order frames.
              if (rx_shift[FRAME_LEN-1 -: 2] == CMD_RD_ADDR) begin
                rd_addr_valid_d = 1'b1;
              end else if (rx_shift[FRAME_LEN-1 -: 2] == CMD_RD_DATA) begin
                rd_addr_valid_d = 1'b0;
              end
            end
          end

          if (state_q == READ_DATA) begin
            if (ram_tx_valid) begin
              miso_d      = ram_dout[ADDR_SIZE-1];
              tx_shift_d  = {ram_dout[ADDR_SIZE-2:0], 1'b0};
              tx_cnt_d    = TX_LAST;
              tx_active_d = 1'b1;
            end else if (tx_active_q) begin
              miso_d     = tx_shift_q[ADDR_SIZE-1];
              tx_shift_d = {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
              tx_cnt_d   = tx_cnt_q - 1'b1;
              if (tx_cnt_q == TX_CNT_W'(1)) begin
                tx_active_d = 1'b0;
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Slave FSM and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rd_addr_valid_q <= 1'b0;
      tx_shift_q      <= '0;
      tx_cnt_q        <= '0;
      tx_active_q     <= 1'b0;
      miso_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rd_addr_valid_q <= rd_addr_valid_d;
      tx_shift_q      <= tx_shift_d;
      tx_cnt_q        <= tx_cnt_d;
      tx_active_q     <= tx_active_d;
      miso_q          <= miso_d;
    end
  end

endmodule

// File: tb/tb_spi_top_module.sv
// Self-checking bench for spi_top_module: directed frames plus randomized
// write/read traffic compared against a behavioural memory model.
`timescale 1ns/1ps
module tb_spi_top_module;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic mosi;
  logic ss_n;
  logic miso;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [7:0] ref_mem [256];
  bit         written [256];
  logic [7:0] ref_wr;
  logic [7:0] ref_rd;
  bit         ref_rd_valid;

  spi_top_module #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8)
  ) dut (
    .mosi  (mosi),
    .ss_n  (ss_n),
    .clk   (clk),
    .rst_n (rst_n),
    .miso  (miso)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Model: apply one complete frame; returns the byte a read frame must produce
  task automatic model_frame(input logic [9:0] f, output logic [7:0] exp);
    exp = 8'h00;
    case (f[9:8])
      CMD_WR_ADDR: ref_wr = f[7:0];
      CMD_WR_DATA: begin
        ref_mem[ref_wr] = f[7:0];
        written[ref_wr] = 1'b1;
`ifdef SPI_WR_AUTOINC_EN
        ref_wr = ref_wr + 8'd1;
`endif
      end
      CMD_RD_ADDR: begin
        ref_rd       = f[7:0];
        ref_rd_valid = 1'b1;
      end
      default: begin
        exp          = ref_rd_valid ? ref_mem[ref_rd] : 8'h00;
        ref_rd_valid = 1'b0;
      end
    endcase
  endtask

  // Drive one full frame; read frames keep ss_n low through E20 and collect miso
  task automatic send_frame(input logic [9:0] f, output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk); ss_n = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk); mosi = f[i];
    end
    @(negedge clk); mosi = 1'b0;
    @(negedge clk);
    if (f[9:8] == CMD_RD_DATA) begin
      check_eq("miso_before_data", {31'd0, miso}, 32'd0);
      for (int k = 7; k >= 0; k--) begin
        @(negedge clk); rd[k] = miso;
      end
      @(negedge clk);
      check_eq("miso_after_data", {31'd0, miso}, 32'd0);
    end
    ss_n = 1'b1;
  endtask

  task automatic do_frame(input logic [9:0] f, input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    send_frame(f, got);
    model_frame(f, exp);
    if (f[9:8] == CMD_RD_DATA) check_eq(tag, {24'd0, got}, {24'd0, exp});
  endtask

  // Start a frame, shift only nbits, then raise ss_n
  task automatic send_partial(input logic [9:0] f, input int unsigned nbits);
    @(negedge clk); ss_n = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) begin
      @(negedge clk); mosi = f[9-i];
    end
    @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
    check_eq("abort_miso", {31'd0, miso}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] d;

    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    ref_wr       = 8'h00;
    ref_rd       = 8'h00;
    ref_rd_valid = 1'b0;

    // Reset
    rst_n = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
    check_eq("reset_miso", {31'd0, miso}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // After reset no read address is latched: a read frame returns zeros
    do_frame({CMD_RD_DATA, 8'h00}, "read_without_addr_after_reset");

    // Directed write
    do_frame({CMD_WR_ADDR, 8'h3C}, "wa");
    do_frame({CMD_WR_DATA, 8'hA5}, "wd");
    check_eq("mem_3c", {24'd0, dut.dut1.mem[8'h3C]}, 32'h0000_00A5);

    // Directed read of 0x96 -> miso 1,0,0,1,0,1,1,0
    do_frame({CMD_WR_ADDR, 8'h10}, "wa");
    do_frame({CMD_WR_DATA, 8'h96}, "wd");
    check_eq("mem_10", {24'd0, dut.dut1.mem[8'h10]}, 32'h0000_0096);
    do_frame({CMD_RD_ADDR, 8'h10}, "ra");
    do_frame({CMD_RD_DATA, 8'h5E}, "read_0x96");
    // The read address is consumed, so a repeat read frame yields zeros
    do_frame({CMD_RD_DATA, 8'h00}, "read_after_consume");

    // Aborted data frame must not write
    do_frame({CMD_WR_ADDR, 8'h5A}, "wa");
    do_frame({CMD_WR_DATA, 8'h33}, "wd");
    check_eq("mem_5a_init", {24'd0, dut.dut1.mem[8'h5A]}, 32'h0000_0033);
    do_frame({CMD_WR_ADDR, 8'h5A}, "wa");
    send_partial({CMD_WR_DATA, 8'hCC}, 5);
    check_eq("mem_5a_after_abort", {24'd0, dut.dut1.mem[8'h5A]}, 32'h0000_0033);
    do_frame({CMD_WR_DATA, 8'hCC}, "wd");
    check_eq("mem_5a_after_retry", {24'd0, dut.dut1.mem[8'h5A]}, 32'h0000_00CC);

    // Address 0xFF boundary with two back-to-back data frames
    do_frame({CMD_WR_ADDR, 8'hFF}, "wa");
    do_frame({CMD_WR_DATA, 8'h11}, "wd");
    do_frame({CMD_WR_DATA, 8'h22}, "wd");
`ifdef SPI_WR_AUTOINC_EN
    check_eq("autoinc_mem_ff", {24'd0, dut.dut1.mem[8'hFF]}, 32'h0000_0011);
    check_eq("autoinc_mem_00", {24'd0, dut.dut1.mem[8'h00]}, 32'h0000_0022);
`else
    check_eq("noinc_mem_ff", {24'd0, dut.dut1.mem[8'hFF]}, 32'h0000_0022);
`endif
    do_frame({CMD_RD_ADDR, 8'hFF}, "ra");
    do_frame({CMD_RD_DATA, 8'h00}, "read_ff");

    // Random write pairs
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      do_frame({CMD_WR_ADDR, a}, "rnd_wa");
      do_frame({CMD_WR_DATA, d}, "rnd_wd");
      check_eq("rnd_wr_peek", {24'd0, dut.dut1.mem[a]}, {24'd0, d});
    end

    // Random read pairs over locations the model knows
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      if (!written[a]) a = 8'h3C;
      do_frame({CMD_RD_ADDR, a}, "rnd_ra");
      do_frame({CMD_RD_DATA, 8'($urandom_range(0, 255))}, "rnd_read");
    end

    // Reset leaves RAM contents intact
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset2_miso", {31'd0, miso}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (written[i]) check_eq("mem_after_reset", {24'd0, dut.dut1.mem[i]}, {24'd0, ref_mem[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
